// File: rtl/ready_valid_fifo_if.sv
// ready_valid_i: ready/valid handshake bundle; m drives data/valid, s drives ready.
interface ready_valid_i #(parameter int W = 8);
  logic [W-1:0] data;
  logic valid;
  logic ready;
  modport m (output data, output valid, input ready);
  modport s (input data, input valid, output ready);
endinterface

// File: rtl/ready_valid_fifo.sv
// ready_valid_fifo: first-word-fall-through FIFO with registered ready/valid on both sides.
module ready_valid_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 8
) (
  input  logic clk,
  input  logic rst_n,
  ready_valid_i.s in,
  ready_valid_i.m out,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ready_valid_fifo: DEPTH must be a power of two >= 2");
  end
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic live, push, pop;
  // live keeps in.ready low until the first edge that samples rst_n high
  assign in.ready = live && count != FULL;
  assign out.valid = count != '0;
  assign out.data = mem[rd_ptr];
  assign push = in.valid && in.ready;
  assign pop = out.valid && out.ready;
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in.data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      live <= 1'b0;
    end else begin
      live <= 1'b1;
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count <= (push && !pop) ? count + (AW+1)'(1) : (pop && !push) ? count - (AW+1)'(1) : count;
    end
  end
endmodule

// File: tb/tb_ready_valid_fifo.sv
// tb_ready_valid_fifo: directed + random checks of ready_valid_fifo against a queue model.
module tb_ready_valid_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b0;
  logic dup = 1'b0;
  logic [2:0] cons_ready = 3'b000;
  logic [2:0] done = 3'b000;
  logic [3:0] count;
  int checks = 0;
  int errors = 0;
  byte unsigned q[$];
  byte unsigned rx0[$], rx1[$], rx2[$];
  bit live = 1'b0;
  bit stall = 1'b0;
  logic [7:0] prev_d = 8'h00;

  ready_valid_i #(.W(8)) in_if ();
  ready_valid_i #(.W(8)) out_if ();

  ready_valid_fifo #(.DEPTH(8), .W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in(in_if), .out(out_if), .count(count)
  );

  always #5 clk = ~clk;
  assign out_if.ready = dup ? &(cons_ready | done) : rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a plain queue; ready = out of reset for an edge and not holding 8
  task automatic step();
    bit p, o;
    p = live && q.size() < 8 && in_if.valid;
    o = q.size() != 0 && out_if.ready;
    stall <= q.size() != 0 && !out_if.ready;
    if (o) void'(q.pop_front());
    if (p) q.push_back(in_if.data);
    live <= 1'b1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      live <= 1'b0;
      stall <= 1'b0;
    end else step();
  end

  always @(negedge clk) begin
    chk("valid", 32'(out_if.valid), 32'(q.size() != 0));
    chk("ready", 32'(in_if.ready), 32'(live && q.size() < 8));
    chk("count", 32'(count), q.size());
    if (q.size() != 0) chk("data", 32'(out_if.data), 32'(q[0]));
    if (stall && rst_n) chk("stable", 32'(out_if.data), 32'(prev_d));
    prev_d <= out_if.data;
  end

  // Three-consumer duplicator stand-in: a word retires once every consumer has taken it
  always @(posedge clk) begin
    if (dup && out_if.valid) begin
      if (cons_ready[0] && !done[0]) rx0.push_back(out_if.data);
      if (cons_ready[1] && !done[1]) rx1.push_back(out_if.data);
      if (cons_ready[2] && !done[2]) rx2.push_back(out_if.data);
      done <= out_if.ready ? 3'b000 : done | cons_ready;
    end
  end

  task automatic drive(input bit v, input logic [7:0] d, input bit r);
    in_if.valid = v;
    in_if.data = d;
    rdy = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent;
    bit acc;
    in_if.valid = 1'b0;
    in_if.data = 8'h00;
    #1;
    chk("rst_valid", 32'(out_if.valid), 0);
    chk("rst_ready", 32'(in_if.ready), 0);
    chk("rst_count", 32'(count), 0);
    #11 rst_n = 1'b1;
    #1 chk("ready_before_edge", 32'(in_if.ready), 0);
    @(posedge clk); #1;
    chk("ready_after_edge", 32'(in_if.ready), 1);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'(i), 1'b0);
      chk("fill_count", 32'(count), i + 1);
    end
    chk("full_ready", 32'(in_if.ready), 0);
    drive(1'b1, 8'h08, 1'b0);
    chk("ninth_refused", 32'(count), 8);
    for (int i = 0; i < 8; i++) begin
      chk("drain_data", 32'(out_if.data), i);
      drive(1'b0, 8'h00, 1'b1);
    end
    chk("drain_valid", 32'(out_if.valid), 0);
    chk("drain_count", 32'(count), 0);
    for (int i = 0; i < 8; i++) drive(1'b1, 8'(8'h20 + i), 1'b0);
    drive(1'b1, 8'h99, 1'b1);
    chk("full_pop_count", 32'(count), 7);
    chk("full_pop_ready", 32'(in_if.ready), 1);
    chk("full_pop_head", 32'(out_if.data), 32'h21);
    for (int i = 0; i < 7; i++) drive(1'b0, 8'h00, 1'b1);
    chk("empty_again", 32'(count), 0);
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 8'(8'h10 + i), 1'b1);
      chk("stream_count", 32'(count), 1);
      chk("stream_data", 32'(out_if.data), 32'(8'(8'h10 + i)));
    end
    drive(1'b0, 8'h00, 1'b1);
    chk("stream_empty", 32'(count), 0);
    for (int i = 0; i < 1000; i++)
      drive($urandom_range(99) < 70, 8'($urandom), $urandom_range(99) < 50);
    for (int i = 0; i < 10; i++) drive(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h30 + i), 1'b0);
    in_if.valid = 1'b0;
    chk("pre_reset_count", 32'(count), 5);
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(out_if.valid), 0);
    chk("async_ready", 32'(in_if.ready), 0);
    chk("async_count", 32'(count), 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 8'hAA, 1'b0);
    chk("post_reset_valid", 32'(out_if.valid), 1);
    chk("post_reset_data", 32'(out_if.data), 32'hAA);
    chk("post_reset_count", 32'(count), 1);
    drive(1'b0, 8'h00, 1'b1);
    chk("post_reset_empty", 32'(out_if.valid), 0);
    dup = 1'b1;
    sent = 0;
    for (int c = 0; c < 400 && !(sent == 12 && !out_if.valid); c++) begin
      cons_ready = {c % 3 == 0, c % 2 == 0, 1'b1};
      in_if.valid = sent < 12;
      in_if.data = 8'(8'h40 + sent);
      acc = in_if.valid && in_if.ready;
      @(posedge clk); #1;
      if (acc) sent++;
    end
    chk("dup_sent", sent, 12);
    chk("dup_rx0_n", rx0.size(), 12);
    chk("dup_rx1_n", rx1.size(), 12);
    chk("dup_rx2_n", rx2.size(), 12);
    for (int i = 0; i < 12; i++) begin
      chk("dup_rx0", i < rx0.size() ? 32'(rx0[i]) : 32'hFFFF, 32'h40 + i);
      chk("dup_rx1", i < rx1.size() ? 32'(rx1[i]) : 32'hFFFF, 32'h40 + i);
      chk("dup_rx2", i < rx2.size() ? 32'(rx2[i]) : 32'hFFFF, 32'h40 + i);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
